// File: rtl/alu_reservation_station_if.sv
// Bundle of dispatch, common-data-bus and issue signals for the ALU
// reservation station. The master side is the dispatcher / execute-unit
// environment; the slave side is the station itself.
interface alu_reservation_station_if #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 4
);
    // Dispatch channel
    logic                          disp_valid;
    logic                          disp_ready;
    logic [4:0]                    disp_alu_op;
    logic [5:0]                    disp_valhw;
    logic [63:0]                   disp_vala;
    logic [63:0]                   disp_valb;
    logic                          disp_a_rdy;
    logic                          disp_b_rdy;
    logic [TAG_W-1:0]              disp_a_tag;
    logic [TAG_W-1:0]              disp_b_tag;
    logic [TAG_W-1:0]              disp_dst_tag;

    // Common data bus broadcast
    logic                          cdb_valid;
    logic [TAG_W-1:0]              cdb_tag;
    logic [63:0]                   cdb_data;

    // Issue channel
    logic                          iss_valid;
    logic                          iss_ready;
    logic [4:0]                    iss_alu_op;
    logic [63:0]                   iss_vala;
    logic [63:0]                   iss_valb;
    logic [5:0]                    iss_valhw;
    logic [TAG_W-1:0]              iss_dst_tag;

    // Occupancy
    logic [$clog2(NUM_ENTRIES):0]  count;

    modport master (
        output disp_valid, disp_alu_op, disp_valhw, disp_vala, disp_valb,
               disp_a_rdy, disp_b_rdy, disp_a_tag, disp_b_tag, disp_dst_tag,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        input  disp_ready, iss_valid, iss_alu_op, iss_vala, iss_valb,
               iss_valhw, iss_dst_tag, count
    );

    modport slave (
        input  disp_valid, disp_alu_op, disp_valhw, disp_vala, disp_valb,
               disp_a_rdy, disp_b_rdy, disp_a_tag, disp_b_tag, disp_dst_tag,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        output disp_ready, iss_valid, iss_alu_op, iss_vala, iss_valb,
               iss_valhw, iss_dst_tag, count
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU operations until both
// operands are available (directly, by dispatch-cycle bypass or by CDB
// wakeup), then issues the oldest ready entry to the execute unit.
module alu_reservation_station #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_reservation_station_if.slave rs
);
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CW = $clog2(NUM_ENTRIES) + 1;
    localparam logic [CW-1:0] FULL_C = CW'(NUM_ENTRIES);

    // Slot storage
    logic [NUM_ENTRIES-1:0] valid_r;
    logic [NUM_ENTRIES-1:0] a_rdy_r;
    logic [NUM_ENTRIES-1:0] b_rdy_r;
    logic [4:0]             op_r     [NUM_ENTRIES];
    logic [63:0]            vala_r   [NUM_ENTRIES];
    logic [63:0]            valb_r   [NUM_ENTRIES];
    logic [TAG_W-1:0]       a_tag_r  [NUM_ENTRIES];
    logic [TAG_W-1:0]       b_tag_r  [NUM_ENTRIES];
    logic [5:0]             valhw_r  [NUM_ENTRIES];
    logic [TAG_W-1:0]       dst_r    [NUM_ENTRIES];
    logic [2:0]             age_r    [NUM_ENTRIES];
    logic [CW-1:0]          count_r;

    // Combinational helpers
    logic [NUM_ENTRIES-1:0] ready_s;
    logic                   sel_found_s;
    logic [IW-1:0]          sel_idx_s;
    logic [2:0]             sel_age_s;
    logic                   free_found_s;
    logic [IW-1:0]          free_idx_s;
    logic                   disp_ready_s;
    logic                   disp_fire_s;
    logic                   iss_fire_s;
    logic [63:0]            new_vala_s;
    logic [63:0]            new_valb_s;
    logic                   new_a_rdy_s;
    logic                   new_b_rdy_s;

    // Readiness uses only registered operand state, so a wakeup is issuable next cycle
    always_comb begin
        ready_s = valid_r & a_rdy_r & b_rdy_r;
    end

    // Oldest-ready selection; strict compare keeps ties on the lowest index
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        sel_age_s   = 3'd0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ready_s[i] && (!sel_found_s || (age_r[i] > sel_age_s))) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IW'(i);
                sel_age_s   = age_r[i];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Lowest-index free slot; scanning downward lets the lowest index win
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IW'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Handshakes; a slot freed by this cycle's issue is not reused until next cycle
    always_comb begin
        disp_ready_s = (count_r < FULL_C);
        disp_fire_s  = rs.disp_valid && disp_ready_s && free_found_s;
        iss_fire_s   = sel_found_s && rs.iss_ready;
    end

    // Dispatch-cycle bypass of operands being broadcast on the CDB right now
    always_comb begin
        if (!rs.disp_a_rdy && rs.cdb_valid && (rs.cdb_tag == rs.disp_a_tag)) begin
            new_vala_s  = rs.cdb_data;
            new_a_rdy_s = 1'b1;
        end else begin
            new_vala_s  = rs.disp_vala;
            new_a_rdy_s = rs.disp_a_rdy;
        end
        if (!rs.disp_b_rdy && rs.cdb_valid && (rs.cdb_tag == rs.disp_b_tag)) begin
            new_valb_s  = rs.cdb_data;
            new_b_rdy_s = 1'b1;
        end else begin
            new_valb_s  = rs.disp_valb;
            new_b_rdy_s = rs.disp_b_rdy;
        end
    end

    // Issue payload from the selected slot, forced to zero when nothing is ready
    always_comb begin
        if (sel_found_s) begin
            rs.iss_alu_op  = op_r[sel_idx_s];
            rs.iss_vala    = vala_r[sel_idx_s];
            rs.iss_valb    = valb_r[sel_idx_s];
            rs.iss_valhw   = valhw_r[sel_idx_s];
            rs.iss_dst_tag = dst_r[sel_idx_s];
        end else begin
            rs.iss_alu_op  = 5'd0;
            rs.iss_vala    = 64'd0;
            rs.iss_valb    = 64'd0;
            rs.iss_valhw   = 6'd0;
            rs.iss_dst_tag = '0;
        end
    end

    assign rs.iss_valid  = sel_found_s;
    assign rs.disp_ready = disp_ready_s;
    assign rs.count      = count_r;

    // Slot update: dispatch write, CDB wakeup, ageing and issue release
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            a_rdy_r <= '0;
            b_rdy_r <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age_r[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (disp_fire_s && (free_idx_s == IW'(i))) begin
                    valid_r[i] <= 1'b1;
                    op_r[i]    <= rs.disp_alu_op;
                    vala_r[i]  <= new_vala_s;
                    a_rdy_r[i] <= new_a_rdy_s;
                    a_tag_r[i] <= rs.disp_a_tag;
                    valb_r[i]  <= new_valb_s;
                    b_rdy_r[i] <= new_b_rdy_s;
                    b_tag_r[i] <= rs.disp_b_tag;
                    valhw_r[i] <= rs.disp_valhw;
                    dst_r[i]   <= rs.disp_dst_tag;
                    age_r[i]   <= 3'd0;
                end else if (valid_r[i]) begin
                    if (rs.cdb_valid && !a_rdy_r[i] && (a_tag_r[i] == rs.cdb_tag)) begin
                        vala_r[i]  <= rs.cdb_data;
                        a_rdy_r[i] <= 1'b1;
                    end
                    if (rs.cdb_valid && !b_rdy_r[i] && (b_tag_r[i] == rs.cdb_tag)) begin
                        valb_r[i]  <= rs.cdb_data;
                        b_rdy_r[i] <= 1'b1;
                    end
                    if (disp_fire_s && (age_r[i] != 3'd7)) begin
                        age_r[i] <= age_r[i] + 3'd1;
                    end
                    if (iss_fire_s && (sel_idx_s == IW'(i))) begin
                        valid_r[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Occupancy counter: simultaneous dispatch and issue cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else begin
            case ({disp_fire_s, iss_fire_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: expected issue payloads
// are queued at dispatch time and compared in order when the station issues.
module tb_alu_reservation_station;
    localparam int NUM_ENTRIES = 4;
    localparam int TAG_W       = 4;
    localparam logic [4:0] PLUS_OP = 5'd0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [142:0] sb_q[$];
    logic [142:0] exp_v;

    alu_reservation_station_if #(.NUM_ENTRIES(NUM_ENTRIES), .TAG_W(TAG_W)) bus ();

    alu_reservation_station #(.NUM_ENTRIES(NUM_ENTRIES), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .rs  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_valid   = 1'b0;
        bus.disp_alu_op  = 5'd0;
        bus.disp_valhw   = 6'd0;
        bus.disp_vala    = 64'd0;
        bus.disp_valb    = 64'd0;
        bus.disp_a_rdy   = 1'b0;
        bus.disp_b_rdy   = 1'b0;
        bus.disp_a_tag   = 4'd0;
        bus.disp_b_tag   = 4'd0;
        bus.disp_dst_tag = 4'd0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_tag      = 4'd0;
        bus.cdb_data     = 64'd0;
    endtask

    task automatic drive_disp(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic ar, input logic br, input logic [3:0] at,
                              input logic [3:0] bt, input logic [3:0] dt, input logic [5:0] hw);
        bus.disp_valid   = 1'b1;
        bus.disp_alu_op  = op;
        bus.disp_vala    = a;
        bus.disp_valb    = b;
        bus.disp_a_rdy   = ar;
        bus.disp_b_rdy   = br;
        bus.disp_a_tag   = at;
        bus.disp_b_tag   = bt;
        bus.disp_dst_tag = dt;
        bus.disp_valhw   = hw;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [63:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    task automatic push_exp(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic [5:0] hw, input logic [3:0] dt);
        sb_q.push_back({op, a, b, hw, dt});
    endtask

    function automatic logic [142:0] got_payload();
        return {bus.iss_alu_op, bus.iss_vala, bus.iss_valb, bus.iss_valhw, bus.iss_dst_tag};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.iss_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got=%b exp=0", bus.iss_valid); end
        checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got=%b exp=1", bus.disp_ready); end
        checks++; if (got_payload() !== 143'd0) begin errors++; $display("FAIL reset_payload got=%h exp=0", got_payload()); end
    endtask

    task automatic test_basic();
        bus.iss_ready = 1'b1;
        drive_disp(PLUS_OP, 64'd5, 64'd7, 1'b1, 1'b1, 4'd0, 4'd0, 4'd3, 6'd12);
        push_exp(PLUS_OP, 64'd5, 64'd7, 6'd12, 4'd3);
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL basic_no_early_issue got=%b exp=0", bus.iss_valid); end
        tick();
        idle_inputs();
        checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL basic_iss_valid got=%b exp=1", bus.iss_valid); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL basic_count1 got=%0d exp=1", bus.count); end
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL basic_payload got=issue exp=empty scoreboard"); end
        else begin exp_v = sb_q.pop_front(); if (got_payload() !== exp_v) begin errors++; $display("FAIL basic_payload got=%h exp=%h", got_payload(), exp_v); end end
        tick();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL basic_count0 got=%0d exp=0", bus.count); end
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got=%b exp=0", bus.iss_valid); end
    endtask

    task automatic test_wakeup();
        bus.iss_ready = 1'b1;
        drive_disp(5'd2, 64'hDEAD, 64'h22, 1'b0, 1'b1, 4'd9, 4'd0, 4'd5, 6'd3);
        push_exp(5'd2, 64'h1234, 64'h22, 6'd3, 4'd5);
        tick();
        idle_inputs();
        cdb(4'd7, 64'hFFFF);  // matches no pending tag
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL wake_wait1 got=%b exp=0", bus.iss_valid); end
        tick();
        idle_inputs();
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL wake_unmatched got=%b exp=0", bus.iss_valid); end
        cdb(4'd9, 64'h1234);
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL wake_cdb_cycle got=%b exp=0", bus.iss_valid); end
        tick();
        idle_inputs();
        checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL wake_iss_valid got=%b exp=1", bus.iss_valid); end
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL wake_payload got=issue exp=empty scoreboard"); end
        else begin exp_v = sb_q.pop_front(); if (got_payload() !== exp_v) begin errors++; $display("FAIL wake_payload got=%h exp=%h", got_payload(), exp_v); end end
        tick();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL wake_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_bypass();
        bus.iss_ready = 1'b1;
        drive_disp(5'd3, 64'h11, 64'h5555, 1'b1, 1'b0, 4'd0, 4'd2, 4'd7, 6'd63);
        cdb(4'd2, 64'hAA);
        push_exp(5'd3, 64'h11, 64'hAA, 6'd63, 4'd7);
        tick();
        idle_inputs();
        checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL bypass_iss_valid got=%b exp=1", bus.iss_valid); end
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL bypass_payload got=issue exp=empty scoreboard"); end
        else begin exp_v = sb_q.pop_front(); if (got_payload() !== exp_v) begin errors++; $display("FAIL bypass_payload got=%h exp=%h", got_payload(), exp_v); end end
        tick();
        // both operands of one slot wake on a single broadcast
        drive_disp(5'd4, 64'h1, 64'h2, 1'b0, 1'b0, 4'd3, 4'd3, 4'd6, 6'd1);
        push_exp(5'd4, 64'h77, 64'h77, 6'd1, 4'd6);
        tick();
        idle_inputs();
        cdb(4'd3, 64'h77);
        tick();
        idle_inputs();
        checks++;
        if (bus.iss_valid !== 1'b1 || sb_q.size() == 0) begin errors++; $display("FAIL dual_wake got=%b exp=1", bus.iss_valid); end
        else begin exp_v = sb_q.pop_front(); if (got_payload() !== exp_v) begin errors++; $display("FAIL dual_wake got=%h exp=%h", got_payload(), exp_v); end end
        tick();
    endtask

    task automatic test_full_order();
        bus.iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_disp(5'(k + 4), 64'(100 + k), 64'(200 + k), 1'b1, 1'b1, 4'd0, 4'd0, 4'(k + 8), 6'(k));
            push_exp(5'(k + 4), 64'(100 + k), 64'(200 + k), 6'(k), 4'(k + 8));
            tick();
        end
        idle_inputs();
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", bus.count); end
        checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL full_disp_ready got=%b exp=0", bus.disp_ready); end
        drive_disp(5'd9, 64'hEEEE, 64'hEEEE, 1'b1, 1'b1, 4'd0, 4'd0, 4'hE, 6'd9);
        tick();
        idle_inputs();
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_reject_count got=%0d exp=4", bus.count); end
        checks++; if (got_payload() !== sb_q[0]) begin errors++; $display("FAIL full_hold_payload got=%h exp=%h", got_payload(), sb_q[0]); end
        bus.iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.iss_valid !== 1'b1 || sb_q.size() == 0) begin errors++; $display("FAIL full_order_valid k=%0d got=%b exp=1", k, bus.iss_valid); end
            else begin exp_v = sb_q.pop_front(); if (got_payload() !== exp_v) begin errors++; $display("FAIL full_order k=%0d got=%h exp=%h", k, got_payload(), exp_v); end end
            tick();
            if (k == 0) begin
                checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_A got=%b exp=1", bus.disp_ready); end
            end
        end
        checks++; if (bus.count !== 3'd0 || bus.iss_valid !== 1'b0) begin errors++; $display("FAIL full_drained got=%0d/%b exp=0/0", bus.count, bus.iss_valid); end
        bus.iss_ready = 1'b0;
    endtask

    task automatic test_full_issue_dispatch();
        bus.iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_disp(5'(k + 12), 64'(300 + k), 64'(400 + k), 1'b1, 1'b1, 4'd0, 4'd0, 4'(k), 6'(k + 20));
            push_exp(5'(k + 12), 64'(300 + k), 64'(400 + k), 6'(k + 20), 4'(k));
            tick();
        end
        bus.iss_ready = 1'b1;
        drive_disp(5'd31, 64'hF00D, 64'hF00D, 1'b1, 1'b1, 4'd0, 4'd0, 4'hF, 6'd0);
        checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL fid_disp_ready got=%b exp=0", bus.disp_ready); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.iss_valid !== 1'b1 || sb_q.size() == 0) begin errors++; $display("FAIL fid_valid k=%0d got=%b exp=1", k, bus.iss_valid); end
            else begin exp_v = sb_q.pop_front(); if (got_payload() !== exp_v) begin errors++; $display("FAIL fid_order k=%0d got=%h exp=%h", k, got_payload(), exp_v); end end
            tick();
            idle_inputs();
            if (k == 0) begin
                checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL fid_count got=%0d exp=3", bus.count); end
            end
        end
        checks++; if (bus.count !== 3'd0 || bus.iss_valid !== 1'b0) begin errors++; $display("FAIL fid_drained got=%0d/%b exp=0/0", bus.count, bus.iss_valid); end
        bus.iss_ready = 1'b0;
    endtask

    task automatic test_age_select();
        bus.iss_ready = 1'b0;
        drive_disp(5'd10, 64'h0, 64'h10, 1'b0, 1'b1, 4'd1, 4'd0, 4'd1, 6'd5);
        tick();
        drive_disp(5'd11, 64'h0, 64'h20, 1'b0, 1'b1, 4'd2, 4'd0, 4'd2, 6'd6);
        tick();
        idle_inputs();
        cdb(4'd2, 64'h2222);
        tick();
        idle_inputs();
        checks++; if (bus.iss_dst_tag !== 4'd2) begin errors++; $display("FAIL age_young_only got=%0d exp=2", bus.iss_dst_tag); end
        cdb(4'd1, 64'h1111);
        tick();
        idle_inputs();
        push_exp(5'd10, 64'h1111, 64'h10, 6'd5, 4'd1);
        push_exp(5'd11, 64'h2222, 64'h20, 6'd6, 4'd2);
        bus.iss_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.iss_valid !== 1'b1 || sb_q.size() == 0) begin errors++; $display("FAIL age_valid k=%0d got=%b exp=1", k, bus.iss_valid); end
            else begin exp_v = sb_q.pop_front(); if (got_payload() !== exp_v) begin errors++; $display("FAIL age_order k=%0d got=%h exp=%h", k, got_payload(), exp_v); end end
            tick();
        end
        bus.iss_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.iss_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 6) begin
                drive_disp(5'(k + 20), 64'(k * 3), 64'(k * 5), 1'b1, 1'b1, 4'd0, 4'd0, 4'(k), 6'(k));
                push_exp(5'(k + 20), 64'(k * 3), 64'(k * 5), 6'(k), 4'(k));
            end else begin
                idle_inputs();
            end
            if (k > 0) begin
                checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL b2b_count k=%0d got=%0d exp=1", k, bus.count); end
                checks++;
                if (bus.iss_valid !== 1'b1 || sb_q.size() == 0) begin errors++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, bus.iss_valid); end
                else begin exp_v = sb_q.pop_front(); if (got_payload() !== exp_v) begin errors++; $display("FAIL b2b_payload k=%0d got=%h exp=%h", k, got_payload(), exp_v); end end
            end
            tick();
        end
        idle_inputs();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL b2b_final_count got=%0d exp=0", bus.count); end
        bus.iss_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_disp(5'd1, 64'd0, 64'd1, 1'b0, 1'b1, 4'(k + 4), 4'd0, 4'(k), 6'd0);
            tick();
        end
        idle_inputs();
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL rmid_count3 got=%0d exp=3", bus.count); end
        rst = 1'b1;
        bus.iss_ready = 1'b1;
        drive_disp(5'd1, 64'd9, 64'd9, 1'b1, 1'b1, 4'd0, 4'd0, 4'd9, 6'd0);
        tick();
        rst = 1'b0;
        idle_inputs();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rmid_count0 got=%0d exp=0", bus.count); end
        checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL rmid_iss_valid got=%b exp=0", bus.iss_valid); end
        checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL rmid_disp_ready got=%b exp=1", bus.disp_ready); end
        for (int k = 0; k < 3; k++) begin
            cdb(4'(k + 4), 64'hBEEF);
            tick();
            idle_inputs();
            checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale_tag k=%0d got=%b exp=0", k, bus.iss_valid); end
        end
        bus.iss_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        bus.iss_ready = 1'b0;
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full_order();
        test_full_issue_dispatch();
        test_age_select();
        test_back_to_back();
        test_reset_mid();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 Parameter NUM_ENTRIES, default 4, number of station slots.
REQ-002 Parameter TAG_W, default 4, producer tag width.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high; sampled on posedge clk only.
REQ-005 disp_valid  in  1  dispatch request. disp_ready  out  1  station can accept.
REQ-006 disp_alu_op  in  5  alu_op_t code. disp_valhw  in  6  shift amount, passed through unchanged.
REQ-007 disp_vala / disp_valb  in  64  operand values. disp_a_rdy / disp_b_rdy  in  1  operand value is valid.
REQ-008 disp_a_tag / disp_b_tag  in  TAG_W  producer tag when operand not ready. disp_dst_tag  in  TAG_W  result tag.
REQ-009 cdb_valid  in  1, cdb_tag  in  TAG_W, cdb_data  in  64  common data bus result broadcast.
REQ-010 iss_valid  out  1  issue request to execute unit. iss_ready  in  1  execute unit accepts.
REQ-011 iss_alu_op  out  5, iss_vala / iss_valb  out  64, iss_valhw  out  6, iss_dst_tag  out  TAG_W  issued payload.
REQ-012 count  out  $clog2(NUM_ENTRIES)+1  number of occupied slots.

Function
REQ-013 Each slot holds: valid, alu_op, vala, a_rdy, a_tag, valb, b_rdy, b_tag, valhw, dst_tag, 3-bit age.
REQ-014 disp_ready = (count < NUM_ENTRIES), computed from current registered state only; a slot freed by this cycle's issue is not reusable until next cycle.
REQ-015 Dispatch fires when disp_valid && disp_ready; payload is written into the lowest-index free slot, age 0.
REQ-016 Dispatch with disp_valid && !disp_ready has no effect and no state change.
REQ-017 Dispatch-cycle bypass: if an incoming operand is not ready and cdb_valid && cdb_tag equals its tag, the slot stores cdb_data with rdy=1.
REQ-018 Wakeup: each cycle with cdb_valid, every valid slot whose operand is not ready and tag equals cdb_tag stores cdb_data and sets rdy=1; both operands of one slot may wake in the same cycle.
REQ-019 A slot is ready when valid && a_rdy && b_rdy as held in registers; a slot woken in cycle t is first issuable in cycle t+1.
REQ-020 Selection: among ready slots, choose the largest age; ties go to the lowest index.
REQ-021 iss_valid = 1 iff any slot is ready; iss_* payload driven combinationally from the selected slot; payload undefined-but-stable (zero) when iss_valid = 0.
REQ-022 Issue fires when iss_valid && iss_ready; the selected slot's valid clears at that posedge.
REQ-023 iss_valid held with iss_ready low: selection and payload remain stable unless an older slot becomes ready.
REQ-024 On every dispatch fire, each other valid slot's age increments, saturating at 7; ages are unchanged by issue or wakeup.
REQ-025 count updates +1 on dispatch only, -1 on issue only, unchanged when both fire in the same cycle.
REQ-026 Dispatch and issue in the same cycle are both performed; dispatch never targets the slot being issued.
REQ-027 cdb_valid with a tag matching no pending operand has no effect.

Reset
REQ-028 While rst is high at posedge: all slot valid bits, rdy bits and ages clear, count = 0.
REQ-029 After reset: iss_valid = 0, iss_* payload = 0, disp_ready = 1.
REQ-030 Reset mid-operation discards all held entries; no issue occurs in the reset cycle; rst has priority over dispatch, wakeup and issue.

Verification
REQ-031 Reset, then dispatch PLUS_OP vala=5 valb=7, both ready, dst_tag=3, iss_ready=1 -> next cycle iss_valid=1, iss_vala=5, iss_valb=7, iss_dst_tag=3; after handshake count=0.
REQ-032 Dispatch with a_rdy=0 a_tag=9; two cycles later cdb_valid, tag=9, data=0x1234 -> iss_valid rises the following cycle with iss_vala=0x1234, never in the CDB cycle.
REQ-033 Dispatch with b_tag=2 while cdb_valid, tag=2, data=0xAA in the same cycle -> slot enters ready; iss_valbb=0xAA next cycle.
REQ-034 iss_ready=0; dispatch 4 ready entries A,B,C,D -> count=4, disp_ready=0; a 5th dispatch is ignored; iss_ready=1 -> issue order A,B,C,D; disp_ready=1 the cycle after A issues.
REQ-035 Full station, iss_ready=1 and disp_valid=1 in the same cycle -> issue occurs, dispatch is rejected, count=3.
REQ-036 Three entries pending, assert rst for one cycle -> count=0, iss_valid=0; a later CDB broadcast with the old tags produces no issue.
